fwd_hazard_unit: RTL

Parametrised operand-forwarding and load-use hazard unit for the in-order integer pipeline. It tracks the destination register and result latency of every instruction between EX and WB. It resolves each source operand of the instruction in ID to either the register file or one of `DEPTH` forwarding taps, and stalls ID when the needed result will not exist in time. It replaces the fixed two-tap, two-operand combinational forwarding logic: tap count, operand count and per-instruction result latency are configurable, and the select is registered into EX.

---
 rtl/fwd_hazard_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load-use stall for the in-order pipeline
module fwd_hazard_unit #(
  parameter int REG_IDX_WIDTH = 5,
  parameter int NUM_SRC       = 2,
  parameter int DEPTH         = 2,
  parameter int SEL_W         = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             id_valid,
  input  logic [NUM_SRC*REG_IDX_WIDTH-1:0] id_rs,
  input  logic [NUM_SRC-1:0]               id_rs_used,
  input  logic                             id_regwrite,
  input  logic [REG_IDX_WIDTH-1:0]         id_rd,
  input  logic [SEL_W-1:0]                 id_lat,
  input  logic                             hold,
  input  logic                             flush,
  output logic                             stall_id,
  output logic [NUM_SRC*SEL_W-1:0]         fwd_sel
);

  localparam logic [SEL_W-1:0] LAT_ONE = SEL_W'(1);
  localparam logic [SEL_W-1:0] LAT_MAX = SEL_W'(DEPTH);

  // Tracker: position 0 is EX, position DEPTH-1 is the stage just before WB.
  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0]         ent_regwrite;
  logic [REG_IDX_WIDTH-1:0] ent_rd  [DEPTH];
  logic [SEL_W-1:0]         ent_lat [DEPTH];

  logic [SEL_W-1:0]         lat_norm;
  logic [NUM_SRC*SEL_W-1:0] cand_sel;
  logic [NUM_SRC-1:0]       hazard;
  logic                     any_hazard;

  // Clamp the incoming latency into the range the taps can actually cover.
  always_comb begin
    lat_norm = id_lat;
    if (id_lat == '0) begin
      lat_norm = LAT_ONE;
    end else if (id_lat > LAT_MAX) begin
      lat_norm = LAT_MAX;
    end
  end

  // Per-operand match scan; older positions first so the youngest match overrides.
  always_comb begin
    cand_sel = '0;
    hazard   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int p = DEPTH - 1; p >= 0; p--) begin
        if (id_valid && id_rs_used[i] &&
            (id_rs[i*REG_IDX_WIDTH +: REG_IDX_WIDTH] != '0) &&
            ent_valid[p] && ent_regwrite[p] &&
            (ent_rd[p] == id_rs[i*REG_IDX_WIDTH +: REG_IDX_WIDTH])) begin
          if (ent_lat[p] <= SEL_W'(p + 1)) begin
            // Result reaches tap p+1 on the edge that moves the consumer into EX.
            cand_sel[i*SEL_W +: SEL_W] = SEL_W'(p + 1);
            hazard[i]                  = 1'b0;
          end else begin
            cand_sel[i*SEL_W +: SEL_W] = '0;
            hazard[i]                  = 1'b1;
          end
        end
      end
    end
  end

  // Stall is combinational; reset masks it so a mid-stall reset releases ID immediately.
  always_comb begin
    any_hazard = |hazard;
    stall_id   = rstn & any_hazard;
  end

  // Tracker advance and registered select, priority reset > flush > hold > stall > push.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ent_valid    <= '0;
      ent_regwrite <= '0;
      for (int p = 0; p < DEPTH; p++) begin
        ent_rd[p]  <= '0;
        ent_lat[p] <= '0;
      end
      fwd_sel <= '0;
    end else if (flush) begin
      // Older entries keep moving; the killed EX instruction lands as a bubble at 1.
      for (int p = 1; p < DEPTH; p++) begin
        ent_valid[p]    <= ent_valid[p-1];
        ent_regwrite[p] <= ent_regwrite[p-1];
        ent_rd[p]       <= ent_rd[p-1];
        ent_lat[p]      <= ent_lat[p-1];
      end
      ent_valid[1]    <= 1'b0;
      ent_regwrite[1] <= 1'b0;
      ent_valid[0]    <= 1'b0;
      ent_regwrite[0] <= 1'b0;
      ent_rd[0]       <= '0;
      ent_lat[0]      <= '0;
      fwd_sel         <= '0;
    end else if (!hold) begin
      for (int p = 1; p < DEPTH; p++) begin
        ent_valid[p]    <= ent_valid[p-1];
        ent_regwrite[p] <= ent_regwrite[p-1];
        ent_rd[p]       <= ent_rd[p-1];
        ent_lat[p]      <= ent_lat[p-1];
      end
      if (any_hazard) begin
        ent_valid[0]    <= 1'b0;
        ent_regwrite[0] <= 1'b0;
        ent_rd[0]       <= '0;
        ent_lat[0]      <= '0;
        fwd_sel         <= '0;
      end else begin
        ent_valid[0]    <= id_valid;
        ent_regwrite[0] <= id_regwrite;
        ent_rd[0]       <= id_rd;
        ent_lat[0]      <= lat_norm;
        fwd_sel         <= cand_sel;
      end
    end
  end

endmodule
